// File: rtl/vga_pkg.sv
// Raster timing constants for 1024x768 @ 60 Hz, 65 MHz pixel clock.
package vga_pkg;

  localparam int HL_TOTAL_TIME  = 1344;
  localparam int HL_BLANK_START = 1024;
  localparam int HL_SYNC_START  = 1048;
  localparam int HL_SYNC_END    = 1184;

  localparam int VL_TOTAL_TIME  = 806;
  localparam int VL_BLANK_START = 768;
  localparam int VL_SYNC_START  = 771;
  localparam int VL_SYNC_END    = 777;

  localparam int HCOUNT_W    = 11;
  localparam int VCOUNT_W    = 11;
  localparam int FRAME_W_DEF = 16;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered blank/sync flags.
// Flags are derived from the next count so they stay aligned with count.
module vga_axis_counter #(
  parameter int TOTAL  = 1344,
  parameter int BLNK   = 1024,
  parameter int SYNC_S = 1048,
  parameter int SYNC_E = 1184,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         blnk,
  output logic         sync,
  output logic         wrap
);

  if (!(BLNK < SYNC_S && SYNC_S < SYNC_E && SYNC_E <= TOTAL &&
        TOTAL <= 2048 && TOTAL <= (1 << W))) begin : g_bad_params
    $error("vga_axis_counter: illegal timing parameters");
  end

  localparam logic [W-1:0] LAST_C   = W'(TOTAL - 1);
  localparam logic [W-1:0] BLNK_C   = W'(BLNK);
  localparam logic [W-1:0] SYNC_S_C = W'(SYNC_S);
  localparam logic [W-1:0] SYNC_E_C = W'(SYNC_E);

  logic [W-1:0] count_q, count_d;
  logic         blnk_q, sync_q;

  assign wrap = inc && (count_q == LAST_C);

  // Next position: hold, increment, or wrap to zero at the end of the axis.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = wrap ? '0 : count_q + W'(1);
  end

  // Counter and flags update on the same edge from the next position.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      blnk_q  <= (count_d >= BLNK_C);
      sync_q  <= (count_d >= SYNC_S_C) && (count_d < SYNC_E_C);
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: h/v counters, blank and sync flags,
// start-of-frame pulse and completed-frame counter. All outputs registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HL_TOTAL  = HL_TOTAL_TIME,
  parameter int HL_BLNK   = HL_BLANK_START,
  parameter int HL_SYNC_S = HL_SYNC_START,
  parameter int HL_SYNC_E = HL_SYNC_END,
  parameter int VL_TOTAL  = VL_TOTAL_TIME,
  parameter int VL_BLNK   = VL_BLANK_START,
  parameter int VL_SYNC_S = VL_SYNC_START,
  parameter int VL_SYNC_E = VL_SYNC_END,
  parameter int FRAME_W   = FRAME_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hblnk,
  output logic                vblnk,
  output logic                hsync,
  output logic                vsync,
  output logic                sof,
  output logic [FRAME_W-1:0]  frame_cnt
);

  logic h_wrap, v_wrap;
  logic sof_q;
  logic [FRAME_W-1:0] frame_q, frame_d;

  vga_axis_counter #(
    .TOTAL(HL_TOTAL), .BLNK(HL_BLNK), .SYNC_S(HL_SYNC_S), .SYNC_E(HL_SYNC_E),
    .W(HCOUNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .inc(en),
    .count(hcount), .blnk(hblnk), .sync(hsync), .wrap(h_wrap)
  );

  // Vertical axis steps once per horizontal wrap; its wrap is the frame wrap.
  vga_axis_counter #(
    .TOTAL(VL_TOTAL), .BLNK(VL_BLNK), .SYNC_S(VL_SYNC_S), .SYNC_E(VL_SYNC_E),
    .W(VCOUNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .count(vcount), .blnk(vblnk), .sync(vsync), .wrap(v_wrap)
  );

  // Frame counter advances on frame wrap, modulo 2^FRAME_W.
  always_comb begin
    frame_d = frame_q;
    if (v_wrap) frame_d = frame_q + FRAME_W'(1);
  end

  // sof only changes on enabled edges so en-qualified consumers see one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      if (en) sof_q <= v_wrap;
      frame_q <= frame_d;
    end
  end

  assign sof       = sof_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a reduced raster (20x10, 3-bit frame counter) so full
// frames and frame-counter wrap stay short. Expected values are hand-computed.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [10:0] hcount, vcount;
  logic        hblnk, vblnk, hsync, vsync, sof;
  logic [2:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // H: total 20, blank from 12, sync 14..16. V: total 10, blank from 6, sync 7..8.
  vga_timing_gen #(
    .HL_TOTAL(20), .HL_BLNK(12), .HL_SYNC_S(14), .HL_SYNC_E(17),
    .VL_TOTAL(10), .VL_BLNK(6),  .VL_SYNC_S(7),  .VL_SYNC_E(9),
    .FRAME_W(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount), .vcount(vcount),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .sof(sof), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {hblnk, vblnk, hsync, vsync, sof}.
  task automatic chk_all(input string tag, input int h, input int v,
                         input logic [4:0] flags, input int fc);
    chk({tag, ".h"},     32'(hcount), 32'(h));
    chk({tag, ".v"},     32'(vcount), 32'(v));
    chk({tag, ".flags"}, 32'({hblnk, vblnk, hsync, vsync, sof}), 32'(flags));
    chk({tag, ".fc"},    32'(frame_cnt), 32'(fc));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    step(2);
    chk_all("reset_hold_en", 0, 0, 5'b00000, 0);

    rst = 1'b0;
    step(1);  chk_all("first_edge", 1, 0, 5'b00000, 0);
    step(10); chk_all("h11",  11, 0, 5'b00000, 0);
    step(1);  chk_all("h12_hblnk_rise", 12, 0, 5'b10000, 0);
    step(2);  chk_all("h14_hsync_first", 14, 0, 5'b10100, 0);
    step(2);  chk_all("h16_hsync_last", 16, 0, 5'b10100, 0);
    step(1);  chk_all("h17_hsync_off", 17, 0, 5'b10000, 0);
    step(2);  chk_all("h19_last", 19, 0, 5'b10000, 0);
    step(1);  chk_all("h_wrap", 0, 1, 5'b00000, 0);

    // cycle count now 20
    step(99); chk_all("v5_end", 19, 5, 5'b10000, 0);
    step(1);  chk_all("v6_vblnk_rise", 0, 6, 5'b01000, 0);
    step(20); chk_all("v7_vsync_first", 0, 7, 5'b01010, 0);
    step(20); chk_all("v8_vsync_last", 0, 8, 5'b01010, 0);
    step(20); chk_all("v9_vsync_off", 0, 9, 5'b01000, 0);
    step(19); chk_all("frame_last", 19, 9, 5'b11000, 0);
    step(1);  chk_all("sof", 0, 0, 5'b00001, 1);
    step(1);  chk_all("sof_one_cycle", 1, 0, 5'b00000, 1);

    // freeze with en=0 at h=10 (cycle 210)
    step(9);
    en = 1'b0;
    step(10); chk_all("en0_frozen", 10, 0, 5'b00000, 1);
    en = 1'b1;
    step(1);  chk_all("en_resume", 11, 0, 5'b00000, 1);

    // next frame wrap at cycle 400; hold sof with en=0
    step(189); chk_all("sof2", 0, 0, 5'b00001, 2);
    en = 1'b0;
    step(3);  chk_all("sof_held", 0, 0, 5'b00001, 2);
    en = 1'b1;
    step(1);  chk_all("sof_released", 1, 0, 5'b00000, 2);

    // mid-frame reset at (15,7)
    step(154); chk_all("pre_reset", 15, 7, 5'b11110, 2);
    rst = 1'b1;
    step(1);  chk_all("mid_reset", 0, 0, 5'b00000, 0);
    rst = 1'b0;

    // frame counter wrap: 7 after 7 frames, 0 after 8
    step(1400); chk_all("fc7", 0, 0, 5'b00001, 7);
    step(200);  chk_all("fc_wrap", 0, 0, 5'b00001, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
